// File: rtl/graph_hop_search_pkg.sv
// Shared types and parameter helpers for the shortest-hop graph search engine.
package graph_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEARCH,
        DONE
    } state_e;

    // Node count for a given index width; adjacency is node_count x node_count bits.
    function automatic int unsigned node_count(input int unsigned node_w);
        return 32'd1 << node_w;
    endfunction

    function automatic bit node_w_legal(input int unsigned node_w);
        return (node_w >= 2) && (node_w <= 5);
    endfunction

    function automatic bit hops_legal(input int unsigned hops);
        return (hops >= 1) && (hops <= 4);
    endfunction

endpackage

// File: rtl/graph_hop_search_if.sv
// Job stream in, result strobe out, for the graph hop search engine.
interface graph_hop_search_if #(
    parameter int NODE_W = 4
);
    logic              in_valid;
    logic [NODE_W-1:0] source;
    logic [NODE_W-1:0] destination;
    logic              out_valid;
    logic              reachable;
    logic [NODE_W-1:0] cost;

    modport master (
        output in_valid, source, destination,
        input  out_valid, reachable, cost
    );

    modport slave (
        input  in_valid, source, destination,
        output out_valid, reachable, cost
    );
endinterface

// File: rtl/graph_hop_search_expand.sv
// One BFS level: a frontier grows by every out-neighbour of its members.
module graph_expand #(
    parameter int N = 16
) (
    input  logic [N-1:0]   frontier,
    input  logic [N*N-1:0] adj,           // row u holds the heads of u's edges
    output logic [N-1:0]   next_frontier
);

    always_comb begin
        // NOTE: assign a default before the loop so no path leaves the output
        // unassigned; otherwise synthesis infers a latch.
        next_frontier = frontier;
        for (int u = 0; u < N; u++) begin
            if (frontier[u]) begin
                next_frontier = next_frontier | adj[u*N +: N];
            end
        end
    end

endmodule

// File: rtl/graph_hop_search.sv
// Shortest-hop BFS engine: loads a small graph from a beat stream, then expands
// HOPS_PER_CYCLE levels per clock until the target is found or the frontier stalls.
module graph_hop_search
    import graph_pkg::*;
#(
    parameter int NODE_W         = 4,
    parameter int HOPS_PER_CYCLE = 2,
    parameter int DIRECTED       = 0
) (
    input logic            clk,
    input logic            rst_n,
    graph_hop_search_if.slave bus
);

    localparam int N  = node_count(NODE_W);
    localparam int H  = HOPS_PER_CYCLE;
    localparam int CW = NODE_W + 3;

    if (!hops_legal(HOPS_PER_CYCLE) || !node_w_legal(NODE_W)) begin : g_param_check
        $error("graph_hop_search: NODE_W must be 2..5 and HOPS_PER_CYCLE 1..4");
    end

    state_e state_q, state_d;

    logic              out_valid_q;
    logic              reachable_q;
    logic [NODE_W-1:0] cost_q;

    logic [N*N-1:0]    adj_q;
    logic [N-1:0]      frontier_q;
    logic [NODE_W-1:0] level_q;
    logic [NODE_W-1:0] target_q;

    logic [H:0][N-1:0] f_chain;
    logic              found;
    logic [2:0]        found_hop;
    logic              stalled;
    logic              expand_en;
    logic              advance;
    logic              finish;
    logic [CW-1:0]     cost_wide;
    logic [CW-1:0]     level_wide;
    logic [NODE_W-1:0] level_next;

    // Expansion chain: f_chain[j] is the set reachable within level_q + j hops.
    assign f_chain[0] = frontier_q;

    for (genvar j = 0; j < H; j++) begin : g_hop
        graph_expand #(.N(N)) u_expand (
            .frontier      (f_chain[j]),
            .adj           (adj_q),
            .next_frontier (f_chain[j+1])
        );
    end

    always_comb begin
        found     = 1'b0;
        found_hop = '0;
        // Descending scan so the smallest hop index wins.
        for (int j = H; j >= 0; j--) begin
            if (f_chain[j][target_q]) begin
                found     = 1'b1;
                found_hop = 3'(j);
            end
        end
    end

    assign stalled    = !found && (f_chain[H] == f_chain[0]);
    assign expand_en  = (state_q == SEARCH) || ((state_q == LOAD) && !bus.in_valid);
    assign advance    = expand_en && !found && !stalled;

    assign cost_wide  = CW'(level_q) + CW'(found_hop);
    assign level_wide = CW'(level_q) + CW'(H);
    assign level_next = (level_wide > CW'(N - 1)) ? {NODE_W{1'b1}} : level_wide[NODE_W-1:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid) state_d = LOAD;
            LOAD:    if (!bus.in_valid) state_d = (found || stalled) ? DONE : SEARCH;
            SEARCH:  if (found || stalled) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign finish = (state_d == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            reachable_q <= 1'b0;
            cost_q      <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples
            // values from before the edge, independent of statement order.
            state_q     <= state_d;
            out_valid_q <= finish;
            reachable_q <= finish && found;
            cost_q      <= (finish && found) ? cost_wide[NODE_W-1:0] : '0;
        end
    end

    // NOTE: adjacency and search state carry no reset; IDLE clears/initialises
    // them before any job uses them, which keeps the wide array off the reset net.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            adj_q <= '0;
            if (bus.in_valid) begin
                target_q   <= bus.destination;
                frontier_q <= {{(N-1){1'b0}}, 1'b1} << bus.source;
                level_q    <= '0;
            end
        end else if ((state_q == LOAD) && bus.in_valid) begin
            adj_q[{bus.source, bus.destination}] <= 1'b1;
            if (DIRECTED == 0) begin
                adj_q[{bus.destination, bus.source}] <= 1'b1;
            end
        end else if (advance) begin
            frontier_q <= f_chain[H];
            level_q    <= level_next;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.reachable = reachable_q;
    assign bus.cost      = cost_q;

endmodule

// File: tb/tb_graph_hop_search.sv
// Directed bench for graph_hop_search across four parameter sets sharing one stimulus bus.
module tb_graph_hop_search;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] src;
    logic [3:0] dst;
    logic [3:0] en;

    int total = 0;
    int bad   = 0;

    logic [3:0] eu[$];
    logic [3:0] ev[$];

    always #5 clk = ~clk;

    // k0: W4 H2 undirected, k1: W4 H2 directed, k2: W4 H1 undirected, k3: W3 H1 undirected
    graph_hop_search_if #(.NODE_W(4)) if0 ();
    graph_hop_search_if #(.NODE_W(4)) if1 ();
    graph_hop_search_if #(.NODE_W(4)) if2 ();
    graph_hop_search_if #(.NODE_W(3)) if3 ();

    assign if0.in_valid = in_valid & en[0];
    assign if1.in_valid = in_valid & en[1];
    assign if2.in_valid = in_valid & en[2];
    assign if3.in_valid = in_valid & en[3];
    assign if0.source = src;       assign if0.destination = dst;
    assign if1.source = src;       assign if1.destination = dst;
    assign if2.source = src;       assign if2.destination = dst;
    assign if3.source = src[2:0];  assign if3.destination = dst[2:0];

    graph_hop_search #(.NODE_W(4), .HOPS_PER_CYCLE(2), .DIRECTED(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    graph_hop_search #(.NODE_W(4), .HOPS_PER_CYCLE(2), .DIRECTED(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    graph_hop_search #(.NODE_W(4), .HOPS_PER_CYCLE(1), .DIRECTED(0)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    graph_hop_search #(.NODE_W(3), .HOPS_PER_CYCLE(1), .DIRECTED(0)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic       ov[4];
    logic       rc[4];
    logic [3:0] cs[4];

    assign ov[0] = if0.out_valid;  assign rc[0] = if0.reachable;  assign cs[0] = if0.cost;
    assign ov[1] = if1.out_valid;  assign rc[1] = if1.reachable;  assign cs[1] = if1.cost;
    assign ov[2] = if2.out_valid;  assign rc[2] = if2.reachable;  assign cs[2] = if2.cost;
    assign ov[3] = if3.out_valid;  assign rc[3] = if3.reachable;  assign cs[3] = {1'b0, if3.cost};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic add_edge(input logic [3:0] u, input logic [3:0] v);
        eu.push_back(u);
        ev.push_back(v);
    endtask

    task automatic add_path(input int last);
        for (int i = 0; i < last; i++) add_edge(4'(i), 4'(i + 1));
    endtask

    // Query beat, queued edge beats, then in_valid low; returns inside search cycle 1.
    task automatic send_job(input int k, input logic [3:0] s, input logic [3:0] t);
        en = 4'b0001 << k;
        @(negedge clk);
        in_valid = 1'b1; src = s; dst = t;
        foreach (eu[i]) begin
            @(negedge clk);
            src = eu[i]; dst = ev[i];
        end
        @(negedge clk);
        in_valid = 1'b0; src = '0; dst = '0;
        eu.delete();
        ev.delete();
    endtask

    task automatic expect_result(input int k, input int exp_cyc, input logic exp_r,
                                 input int exp_cost, input string tag);
        int         cyc = 0;
        logic       r   = 1'b0;
        logic [3:0] c   = '0;
        for (int n = 2; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ov[k]) begin
                cyc = n; r = rc[k]; c = cs[k];
                break;
            end
        end
        check({tag, ".cycle"}, cyc, exp_cyc);
        check({tag, ".reachable"}, {31'd0, r}, {31'd0, exp_r});
        check({tag, ".cost"}, {28'd0, c}, exp_cost);
        @(posedge clk); #1;
        check({tag, ".strobe_width"}, {31'd0, ov[k]}, 0);
        check({tag, ".idle_cost"}, {28'd0, cs[k]}, 0);
        check({tag, ".idle_reach"}, {31'd0, rc[k]}, 0);
    endtask

    // Long path job aborted by reset in search cycle 3; the result must never appear.
    task automatic reset_mid(input int k, input string tag);
        int seen = 0;
        add_path(5);
        send_job(k, 4'd0, 4'd5);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, ".rst_valid"}, {31'd0, ov[k]}, 0);
        check({tag, ".rst_cost"}, {28'd0, cs[k]}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (ov[k]) seen++;
        end
        check({tag, ".no_result_after_abort"}, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; src = '0; dst = '0; en = '0;
        #12;
        check("reset.k0_valid", {31'd0, ov[0]}, 0);
        check("reset.k0_reach", {31'd0, rc[0]}, 0);
        check("reset.k0_cost",  {28'd0, cs[0]}, 0);
        check("reset.k3_valid", {31'd0, ov[3]}, 0);
        check("reset.k3_cost",  {28'd0, cs[3]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // W4 H2 undirected
        add_path(5);
        send_job(0, 4'd0, 4'd5);                 expect_result(0, 4, 1'b1, 5, "k0.path05");
        add_edge(0, 1);
        send_job(0, 4'd3, 4'd3);                 expect_result(0, 2, 1'b1, 0, "k0.self");
        add_edge(0, 1); add_edge(1, 2);
        send_job(0, 4'd0, 4'd9);                 expect_result(0, 3, 1'b0, 0, "k0.unreach");
        add_edge(0, 1); add_edge(1, 2);
        send_job(0, 4'd2, 4'd0);                 expect_result(0, 2, 1'b1, 2, "k0.reverse");
        add_path(4); add_edge(0, 4);
        send_job(0, 4'd0, 4'd4);                 expect_result(0, 2, 1'b1, 1, "k0.shortcut");
        send_job(0, 4'd7, 4'd8);                 expect_result(0, 2, 1'b0, 0, "k0.no_edges");

        // W4 H2 directed
        add_edge(0, 1); add_edge(1, 2);
        send_job(1, 4'd2, 4'd0);                 expect_result(1, 2, 1'b0, 0, "k1.reverse");
        add_edge(0, 1); add_edge(1, 2);
        send_job(1, 4'd0, 4'd2);                 expect_result(1, 2, 1'b1, 2, "k1.forward");

        // W4 H1 undirected
        add_path(4); add_edge(0, 4);
        send_job(2, 4'd0, 4'd4);                 expect_result(2, 2, 1'b1, 1, "k2.shortcut");
        add_path(5);
        send_job(2, 4'd0, 4'd5);                 expect_result(2, 6, 1'b1, 5, "k2.path05");

        // Abort then clean-adjacency job, W4 H2
        reset_mid(0, "k0.abort");
        add_edge(0, 1);
        send_job(0, 4'd0, 4'd2);                 expect_result(0, 3, 1'b0, 0, "k0.after_abort");

        // W3 H1 undirected
        add_path(5);
        send_job(3, 4'd0, 4'd5);                 expect_result(3, 6, 1'b1, 5, "k3.path05");
        add_edge(0, 1);
        send_job(3, 4'd3, 4'd3);                 expect_result(3, 2, 1'b1, 0, "k3.self");
        add_edge(0, 1); add_edge(1, 2);
        send_job(3, 4'd0, 4'd7);                 expect_result(3, 4, 1'b0, 0, "k3.unreach");
        add_edge(0, 1); add_edge(1, 2);
        send_job(3, 4'd2, 4'd0);                 expect_result(3, 3, 1'b1, 2, "k3.reverse");
        add_path(4); add_edge(0, 4);
        send_job(3, 4'd0, 4'd4);                 expect_result(3, 2, 1'b1, 1, "k3.shortcut");
        reset_mid(3, "k3.abort");
        add_edge(0, 1);
        send_job(3, 4'd0, 4'd2);                 expect_result(3, 3, 1'b0, 0, "k3.after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/graph_hop_search.md
Name: graph_hop_search

Overview:
- Shortest-hop-count engine for a small graph loaded on a streaming interface.
- Per job: first in_valid beat carries the query pair (start, target); the following beats carry edges.
- After in_valid falls, the engine runs a frontier BFS at HOPS_PER_CYCLE levels per clock.
- Returns the minimum hop count, or an unreachable flag. Generalises the fixed 16-node, 2-hop, undirected searcher to parametrised node count, expansion depth and directed/undirected mode.

Parameters:
NODE_W, 4, node index width; N = 2**NODE_W nodes (legal 2..5).
HOPS_PER_CYCLE, 2, BFS levels evaluated per clock (legal 1..4).
DIRECTED, 0, 0: edge beat adds u-v both ways; 1: adds u->v only.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat valid; high for one contiguous burst per job
source  input  NODE_W  beat 1: start node; later beats: edge tail u
destination  input  NODE_W  beat 1: target node; later beats: edge head v
out_valid  output  1  one-cycle result strobe
reachable  output  1  target reachable from start; valid with out_valid
cost  output  NODE_W  minimum hop count; 0 when unreachable or start==target

Behaviour:
- Clock and reset: clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE; out_valid=0, reachable=0, cost=0. Adjacency and frontier contents are don't-care at reset.
- Outputs are registered. When out_valid=0, cost=0 and reachable=0.
- States:
  - IDLE: adjacency cleared every cycle. On in_valid, latch start/target, set frontier = {start}, level=0, go to LOAD.
  - LOAD: each in_valid beat sets adj[u][v] (and adj[v][u] if DIRECTED=0). Self-loops and duplicate edges are harmless. The first cycle with in_valid=0 is search cycle 1; the engine goes to SEARCH and performs that cycle's expansion.
  - SEARCH: expansion each cycle (see below) until found or stalled.
  - DONE: out_valid=1 for exactly one cycle, then IDLE.
- Expansion per search cycle:
  - Chain F0=frontier, Fj = Fj-1 | neighbours(Fj-1), for j=1..H where H = HOPS_PER_CYCLE.
  - Found if target is in some Fj, j=0..H. Take the smallest such j; cost = level + j.
  - Stalled if not found and FH == F0; then reachable=0, cost=0.
  - Otherwise frontier <= FH, level <= level+H.
  - Found and stalled are evaluated in the same cycle; found has priority.
- Latency: for distance D, out_valid rises in cycle ceil(D/H)+1, counting search cycle 1 as cycle 1. For D=0 this is cycle 2. For unreachable: one cycle after the first non-growing search cycle.
- level saturates at N-1; it cannot overflow because the search stalls within N-1 levels.
- in_valid during SEARCH/DONE is ignored. Jobs are separated by at least one in_valid-low cycle after out_valid.
- A job with only the query beat (no edges) is legal.
- Reset mid-operation aborts the job; the next job starts from clean adjacency.

Decomposition:
- Package graph_pkg: state enum {IDLE, LOAD, SEARCH, DONE}; localparam N derived from NODE_W; HOPS_PER_CYCLE legality check.
- Sub-module graph_expand: purely combinational one-hop frontier expansion (frontier + adjacency -> next frontier), instantiated H times in a chain. Adjacency is stored as full N x N bits; undirected mode writes both halves.

Test Plan:
- Path 0-1-2-3-4-5, query (0,5), H=2, undirected -> out_valid in cycle 4, cost=5, reachable=1.
- Query (3,3) with edges 0-1 -> out_valid in cycle 2, cost=0, reachable=1.
- Query (0,9), edges 0-1, 1-2 -> no growth in cycle 2, out_valid in cycle 3, reachable=0, cost=0.
- Query (2,0), edges 0->1, 1->2:
  - DIRECTED=1 -> cycle 2, reachable=0, cost=0.
  - DIRECTED=0 -> cycle 2, reachable=1, cost=2.
- Chain 0-1-2-3-4 plus shortcut 0-4, query (0,4), H=1 and H=2 -> cost=1, out_valid in cycle 2.
- Reset asserted mid-SEARCH -> out_valid=0 immediately. Next job: query (0,2), edge 0-1 only -> reachable=0, proving adjacency was cleared. Repeat the whole set with NODE_W=3, H=1.
